// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit controller: command codes,
// instruction bytes, delay constants and the init-sequence table.
package lcd_pkg;

  typedef enum logic [1:0] {
    CMD_CHAR  = 2'd0,
    CMD_CLEAR = 2'd1,
    CMD_GOTO  = 2'd2,
    CMD_RAW   = 2'd3
  } cmd_type_e;

  // Post-byte / post-nibble wait selector.
  typedef enum logic [1:0] {W_40, W_100, W_1640, W_4100} wait_sel_e;

  localparam logic [7:0] INS_CLEAR     = 8'h01;
  localparam logic [7:0] INS_ENTRY     = 8'h06;
  localparam logic [7:0] INS_DISP_ON   = 8'h0C;
  localparam logic [7:0] INS_FSET_4B   = 8'h20;
  localparam logic [7:0] INS_FSET_2L   = 8'h08;
  localparam logic [7:0] INS_SET_DDRAM = 8'h80;

  localparam int unsigned T_NIB_US   = 1;
  localparam int unsigned T_SHORT_US = 40;
  localparam int unsigned T_MID_US   = 100;
  localparam int unsigned T_LONG_US  = 1640;
  localparam int unsigned T_POR_US   = 4100;

  localparam logic [2:0] INIT_LAST = 3'd7;

  // One init step: a lone high nibble (in data[7:4]) or a full byte, plus its wait.
  typedef struct packed {
    logic      nib_only;
    logic [7:0] data;
    wait_sel_e wsel;
  } init_item_t;

  // Microseconds to clock cycles; never returns zero so timers always advance.
  function automatic int unsigned us_to_cyc(input int unsigned clk_hz, input int unsigned us);
    int unsigned c;
    c = (clk_hz / 32'd1_000_000) * us;
    return (c == 32'd0) ? 32'd1 : c;
  endfunction

  // DDRAM start address of each display row.
  function automatic logic [7:0] row_base(input logic [1:0] row, input int unsigned cols);
    case (row)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'(cols);
      default: return 8'(32'h40 + cols);
    endcase
  endfunction

  // Clear and return-home need the long execution time.
  function automatic logic is_long_instr(input logic [7:0] data);
    return (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

  // Power-up init table: three 0x3 wake-ups, switch to 4-bit, then configure.
  function automatic init_item_t init_item(input logic [2:0] step, input int unsigned rows);
    init_item_t it;
    it = '{1'b0, INS_ENTRY, W_40};
    case (step)
      3'd0:    it = '{1'b1, 8'h30, W_4100};
      3'd1:    it = '{1'b1, 8'h30, W_100};
      3'd2:    it = '{1'b1, 8'h30, W_40};
      3'd3:    it = '{1'b1, 8'h20, W_40};
      3'd4:    it = '{1'b0, (rows > 1) ? (INS_FSET_4B | INS_FSET_2L) : INS_FSET_4B, W_40};
      3'd5:    it = '{1'b0, INS_DISP_ON, W_40};
      3'd6:    it = '{1'b0, INS_CLEAR, W_1640};
      default: it = '{1'b0, INS_ENTRY, W_40};
    endcase
    return it;
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// Command channel between the display-formatting logic and the LCD controller.
interface lcd_hd44780_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic [1:0] cmd_row;
  logic [5:0] cmd_col;

  modport master (output cmd_valid, cmd_type, cmd_data, cmd_row, cmd_col, input cmd_ready);
  modport slave  (input cmd_valid, cmd_type, cmd_data, cmd_row, cmd_col, output cmd_ready);
endinterface

// File: rtl/lcd_nibble_tx.sv
// Sends one 4-bit nibble: SETUP (e=0), E_HI (e=1), HOLD (e=0), each NIB_CYC cycles.
// rs/d are latched on start and held until the next start.
module lcd_nibble_tx #(
  parameter int unsigned NIB_CYC = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_d
);

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_EHI, PH_HOLD} phase_e;

  phase_e      phase, phase_nxt;
  logic [31:0] cnt;
  logic        ph_last;

  assign ph_last = (cnt == NIB_CYC - 1);

  // Phase sequencing; each timed phase ends when the counter reaches NIB_CYC-1.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_IDLE:  if (start)   phase_nxt = PH_SETUP;
      PH_SETUP: if (ph_last) phase_nxt = PH_EHI;
      PH_EHI:   if (ph_last) phase_nxt = PH_HOLD;
      PH_HOLD:  if (ph_last) phase_nxt = PH_IDLE;
      default:               phase_nxt = PH_IDLE;
    endcase
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) phase <= PH_IDLE;
    else     phase <= phase_nxt;
  end

  // Phase timer, pin registers and the one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      done   <= 1'b0;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_d  <= '0;
    end else begin
      if (phase != phase_nxt)   cnt <= '0;
      else if (phase != PH_IDLE) cnt <= cnt + 32'd1;
      if (phase == PH_IDLE && start) begin
        lcd_rs <= rs;
        lcd_d  <= nibble;
      end
      lcd_e <= (phase_nxt == PH_EHI);
      done  <= (phase == PH_HOLD) && ph_last;
    end
  end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit controller: power-up wait, init sequence, then CHAR/CLEAR/GOTO/RAW
// commands with cursor tracking and automatic line wrap.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 12_000_000,
  parameter int unsigned COLS     = 16,
  parameter int unsigned ROWS     = 2,
  parameter int unsigned PWRUP_US = 40000
) (
  input  logic                     clk,
  input  logic                     rst,
  lcd_hd44780_ctrl_if.slave        cmd,
  output logic                     init_done,
  output logic [1:0]               cur_row,
  output logic [5:0]               cur_col,
  output logic                     lcd_rs,
  output logic                     lcd_e,
  output logic [3:0]               lcd_d
);

  localparam int unsigned NIB_CYC   = us_to_cyc(CLK_HZ, T_NIB_US);
  localparam int unsigned PWRUP_CYC = us_to_cyc(CLK_HZ, PWRUP_US);
  localparam int unsigned W40_CYC   = us_to_cyc(CLK_HZ, T_SHORT_US);
  localparam int unsigned W100_CYC  = us_to_cyc(CLK_HZ, T_MID_US);
  localparam int unsigned W1640_CYC = us_to_cyc(CLK_HZ, T_LONG_US);
  localparam int unsigned W4100_CYC = us_to_cyc(CLK_HZ, T_POR_US);
  localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
  localparam logic [1:0]  LAST_ROW  = 2'(ROWS - 1);

  typedef enum logic [2:0] {ST_PWRUP, ST_IDLE, ST_SEND, ST_WAIT, ST_WRAP} state_e;

  state_e      state, state_nxt;
  logic [31:0] timer, wait_lim;
  logic [7:0]  tx_byte;
  logic [3:0]  tx_nib;
  logic        tx_rs, tx_nib_only, tx_lo, tx_start, tx_done;
  wait_sel_e   tx_wsel;
  logic [2:0]  istep, istep_nx;
  init_item_t  init_nx;
  logic        wrap_pend, accept, pwrup_end, wait_end, byte_end, init_load;
  logic [1:0]  goto_row;
  logic [5:0]  goto_col;

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign tx_nib        = tx_lo ? tx_byte[3:0] : tx_byte[7:4];

  // Decode helpers: acceptance, timer expiries, next init step, clamped GOTO target.
  always_comb begin
    accept   = (state == ST_IDLE) && cmd.cmd_valid;
    istep_nx = (state == ST_PWRUP) ? 3'd0 : istep + 3'd1;
    init_nx  = init_item(istep_nx, ROWS);
    wait_lim = W40_CYC;
    case (tx_wsel)
      W_100:   wait_lim = W100_CYC;
      W_1640:  wait_lim = W1640_CYC;
      W_4100:  wait_lim = W4100_CYC;
      default: wait_lim = W40_CYC;
    endcase
    pwrup_end = (timer == PWRUP_CYC - 1);
    wait_end  = (timer == wait_lim - 32'd1);
    byte_end  = tx_done && (tx_nib_only || tx_lo);
    init_load = ((state == ST_PWRUP) && pwrup_end) ||
                ((state == ST_WAIT) && wait_end && !init_done && (istep != INIT_LAST));
    goto_row  = (cmd.cmd_row > LAST_ROW) ? LAST_ROW : cmd.cmd_row;
    goto_col  = (cmd.cmd_col > LAST_COL) ? LAST_COL : cmd.cmd_col;
  end

  // Next-state logic for the init and command sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_PWRUP: if (pwrup_end) state_nxt = ST_SEND;
      ST_IDLE:  if (accept)    state_nxt = ST_SEND;
      ST_SEND:  if (byte_end)  state_nxt = ST_WAIT;
      ST_WAIT:
        if (wait_end) begin
          if (!init_done) state_nxt = (istep == INIT_LAST) ? ST_IDLE : ST_SEND;
          else            state_nxt = wrap_pend ? ST_WRAP : ST_IDLE;
        end
      ST_WRAP:  state_nxt = ST_SEND;
      default:  state_nxt = ST_PWRUP;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_PWRUP;
    else     state <= state_nxt;
  end

  // Control: timers, nibble start strobes, init progress and cursor tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= '0;
      tx_start  <= 1'b0;
      tx_lo     <= 1'b0;
      istep     <= '0;
      init_done <= 1'b0;
      cur_row   <= '0;
      cur_col   <= '0;
      wrap_pend <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (state != state_nxt) timer <= '0;
      else if (state == ST_PWRUP || state == ST_WAIT) timer <= timer + 32'd1;
      if (init_load) begin
        istep    <= istep_nx;
        tx_lo    <= 1'b0;
        tx_start <= 1'b1;
      end
      case (state)
        ST_WAIT:
          if (wait_end && !init_done && istep == INIT_LAST) begin
            init_done <= 1'b1;
            cur_row   <= '0;
            cur_col   <= '0;
          end
        ST_SEND:
          if (tx_done && !byte_end) begin
            tx_lo    <= 1'b1;
            tx_start <= 1'b1;
          end
        ST_WRAP: begin
          wrap_pend <= 1'b0;
          tx_lo     <= 1'b0;
          tx_start  <= 1'b1;
        end
        ST_IDLE:
          if (accept) begin
            tx_lo    <= 1'b0;
            tx_start <= 1'b1;
            case (cmd_type_e'(cmd.cmd_type))
              CMD_CHAR:
                if (cur_col == LAST_COL) begin
                  cur_col   <= '0;
                  cur_row   <= (cur_row == LAST_ROW) ? 2'd0 : cur_row + 2'd1;
                  wrap_pend <= 1'b1;
                end else begin
                  cur_col <= cur_col + 6'd1;
                end
              CMD_CLEAR: begin
                cur_row <= '0;
                cur_col <= '0;
              end
              CMD_GOTO: begin
                cur_row <= goto_row;
                cur_col <= goto_col;
              end
              default: ;
            endcase
          end
        default: ;
      endcase
    end
  end

  // Byte to transmit, its register select and post-byte wait, captured at load time.
  always_ff @(posedge clk) begin
    if (init_load) begin
      tx_byte     <= init_nx.data;
      tx_rs       <= 1'b0;
      tx_nib_only <= init_nx.nib_only;
      tx_wsel     <= init_nx.wsel;
    end else if (state == ST_WRAP) begin
      tx_byte     <= INS_SET_DDRAM | row_base(cur_row, COLS);
      tx_rs       <= 1'b0;
      tx_nib_only <= 1'b0;
      tx_wsel     <= W_40;
    end else if (accept) begin
      tx_nib_only <= 1'b0;
      case (cmd_type_e'(cmd.cmd_type))
        CMD_CHAR: begin
          tx_byte <= cmd.cmd_data;
          tx_rs   <= 1'b1;
          tx_wsel <= W_40;
        end
        CMD_CLEAR: begin
          tx_byte <= INS_CLEAR;
          tx_rs   <= 1'b0;
          tx_wsel <= W_1640;
        end
        CMD_GOTO: begin
          tx_byte <= INS_SET_DDRAM | (row_base(goto_row, COLS) + {2'b00, goto_col});
          tx_rs   <= 1'b0;
          tx_wsel <= W_40;
        end
        default: begin
          tx_byte <= cmd.cmd_data;
          tx_rs   <= 1'b0;
          tx_wsel <= is_long_instr(cmd.cmd_data) ? W_1640 : W_40;
        end
      endcase
    end
  end

  lcd_nibble_tx #(.NIB_CYC(NIB_CYC)) u_nibble_tx (
    .clk    (clk),
    .rst    (rst),
    .start  (tx_start),
    .nibble (tx_nib),
    .rs     (tx_rs),
    .done   (tx_done),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_d  (lcd_d)
  );

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl with a nibble scoreboard.
module tb_lcd_hd44780_ctrl;

  localparam int CLK_PER   = 10;
  localparam int US        = 2;
  localparam int PWRUP_CYC = 200 * US;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done;
  logic [1:0] cur_row;
  logic [5:0] cur_col;
  logic       lcd_rs, lcd_e;
  logic [3:0] lcd_d;

  lcd_hd44780_ctrl_if cif();

  lcd_hd44780_ctrl #(
    .CLK_HZ(2_000_000), .COLS(16), .ROWS(2), .PWRUP_US(200)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cif), .init_done(init_done),
    .cur_row(cur_row), .cur_col(cur_col),
    .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_d(lcd_d)
  );

  always #(CLK_PER / 2) clk = ~clk;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         min_gap;
  } exp_t;

  exp_t   q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint ref_t = 0;
  longint rise_t = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ge(input string tag, input longint obs, input longint lim);
    n_cmp++;
    assert (obs >= lim) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected >= %0d", tag, obs, lim);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_nib(input logic rs, input logic [3:0] n, input int gap);
    exp_t e;
    e.rs = rs; e.nib = n; e.min_gap = gap;
    q.push_back(e);
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b, input int gap);
    push_nib(rs, b[7:4], gap);
    push_nib(rs, b[3:0], 0);
  endtask

  task automatic push_init();
    push_nib(1'b0, 4'h3, PWRUP_CYC);
    push_nib(1'b0, 4'h3, 4100 * US);
    push_nib(1'b0, 4'h3, 100 * US);
    push_nib(1'b0, 4'h2, 40 * US);
    push_byte(1'b0, 8'h28, 40 * US);
    push_byte(1'b0, 8'h0C, 40 * US);
    push_byte(1'b0, 8'h01, 40 * US);
    push_byte(1'b0, 8'h06, 1640 * US);
  endtask

  task automatic wait_ready(input string tag, output int cyc);
    cyc = 0;
    while (cif.cmd_ready !== 1'b1 && cyc < 30000) begin
      tick();
      cyc++;
    end
    chk({tag, "_ready"}, longint'(cif.cmd_ready), 1);
  endtask

  task automatic send_cmd(input logic [1:0] ty, input logic [7:0] d,
                          input logic [1:0] r, input logic [5:0] c);
    int cyc;
    wait_ready("pre_cmd", cyc);
    cif.cmd_type = ty; cif.cmd_data = d; cif.cmd_row = r; cif.cmd_col = c;
    cif.cmd_valid = 1'b1;
    tick();
    cif.cmd_valid = 1'b0;
    cif.cmd_type = ~ty; cif.cmd_data = ~d; cif.cmd_row = ~r; cif.cmd_col = ~c;
    chk("ready_drop", longint'(cif.cmd_ready), 0);
  endtask

  // Scoreboard: every E rising edge must match the oldest expected nibble.
  always @(posedge lcd_e) begin
    exp_t e;
    rise_t = longint'($time);
    if (q.size() == 0) begin
      chk_ge("nibble_expected", longint'(q.size()), 1);
    end else begin
      e = q.pop_front();
      chk("nib_rs", longint'(lcd_rs), longint'(e.rs));
      chk("nib_data", longint'(lcd_d), longint'(e.nib));
      if (e.min_gap > 0)
        chk_ge("nib_gap_cycles", (rise_t - ref_t) / CLK_PER, longint'(e.min_gap));
    end
  end

  // E high width check; falling edge is the reference for the next gap.
  always @(negedge lcd_e) begin
    if (rst === 1'b0)
      chk("e_high_cycles", (longint'($time) - rise_t) / CLK_PER, longint'(US));
    ref_t = longint'($time);
  end

  initial begin
    int     k;
    int     cyc;
    logic   seen_e;
    cif.cmd_valid = 1'b0; cif.cmd_type = 2'd0; cif.cmd_data = 8'h00;
    cif.cmd_row = 2'd0; cif.cmd_col = 6'd0;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_lcd_e", longint'(lcd_e), 0);
    chk("rst_lcd_rs", longint'(lcd_rs), 0);
    chk("rst_lcd_d", longint'(lcd_d), 0);
    chk("rst_ready", longint'(cif.cmd_ready), 0);
    chk("rst_init_done", longint'(init_done), 0);
    chk("rst_cur_col", longint'(cur_col), 0);

    rst = 1'b0;
    ref_t = longint'($time);
    push_init();
    seen_e = 1'b0;
    for (int i = 0; i < PWRUP_CYC; i++) begin
      tick();
      if (lcd_e === 1'b1) seen_e = 1'b1;
    end
    chk("pwrup_e_quiet", longint'(seen_e), 0);
    wait_ready("init", cyc);
    chk("init_done", longint'(init_done), 1);
    chk("init_cur_row", longint'(cur_row), 0);
    chk("init_cur_col", longint'(cur_col), 0);
    chk("init_all_nibbles", longint'(q.size()), 0);

    // CHAR 'H' and acceptance-to-E latency
    push_byte(1'b1, 8'h48, 40 * US);
    send_cmd(2'd0, 8'h48, 2'd0, 6'd0);
    k = 0;
    while (lcd_e !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk("accept_to_e_cycles", longint'(k), longint'(1 + US));
    wait_ready("char_h", cyc);
    chk("h_cur_col", longint'(cur_col), 1);
    chk("h_cur_row", longint'(cur_row), 0);
    chk("h_nibbles", longint'(q.size()), 0);

    // Fill the rest of row 0; the 16th character wraps to row 1
    for (int i = 0; i < 15; i++) begin
      push_byte(1'b1, 8'h41 + 8'(i), 40 * US);
      if (i == 14) push_byte(1'b0, 8'hC0, 40 * US);
      send_cmd(2'd0, 8'h41 + 8'(i), 2'd0, 6'd0);
    end
    wait_ready("wrap", cyc);
    chk("wrap_cur_row", longint'(cur_row), 1);
    chk("wrap_cur_col", longint'(cur_col), 0);
    chk("wrap_nibbles", longint'(q.size()), 0);

    // GOTO out of range clamps to (1,15)
    push_byte(1'b0, 8'hCF, 40 * US);
    send_cmd(2'd2, 8'h00, 2'd3, 6'd50);
    wait_ready("goto", cyc);
    chk("goto_cur_row", longint'(cur_row), 1);
    chk("goto_cur_col", longint'(cur_col), 15);

    // CHAR at last cell of last row wraps to row 0
    push_byte(1'b1, 8'h65, 40 * US);
    push_byte(1'b0, 8'h80, 40 * US);
    send_cmd(2'd0, 8'h65, 2'd0, 6'd0);
    wait_ready("wrap_last", cyc);
    chk("wrap_last_row", longint'(cur_row), 0);
    chk("wrap_last_col", longint'(cur_col), 0);

    // GOTO in range, then CLEAR with long busy time
    push_byte(1'b0, 8'hC3, 40 * US);
    send_cmd(2'd2, 8'h00, 2'd1, 6'd3);
    wait_ready("goto2", cyc);
    chk("goto2_cur_col", longint'(cur_col), 3);
    push_byte(1'b0, 8'h01, 40 * US);
    send_cmd(2'd1, 8'h00, 2'd0, 6'd0);
    wait_ready("clear", cyc);
    chk_ge("clear_busy_cycles", longint'(cyc), longint'(1640 * US));
    chk("clear_cur_row", longint'(cur_row), 0);
    chk("clear_cur_col", longint'(cur_col), 0);

    // CHAR then RAW: RAW leaves the cursor alone
    push_byte(1'b1, 8'h78, 1640 * US);
    send_cmd(2'd0, 8'h78, 2'd0, 6'd0);
    push_byte(1'b0, 8'h0C, 40 * US);
    send_cmd(2'd3, 8'h0C, 2'd0, 6'd0);
    wait_ready("raw", cyc);
    chk("raw_cur_col", longint'(cur_col), 1);
    chk("raw_cur_row", longint'(cur_row), 0);
    chk("raw_nibbles", longint'(q.size()), 0);

    // Reset during E high of a CHAR
    push_nib(1'b1, 4'h5, 40 * US);
    send_cmd(2'd0, 8'h5A, 2'd0, 6'd0);
    k = 0;
    while (lcd_e !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk("midrst_e_high", longint'(lcd_e), 1);
    rst = 1'b1;
    tick();
    chk("midrst_lcd_e", longint'(lcd_e), 0);
    chk("midrst_ready", longint'(cif.cmd_ready), 0);
    chk("midrst_init_done", longint'(init_done), 0);
    chk("midrst_cur_col", longint'(cur_col), 0);
    chk("midrst_lcd_d", longint'(lcd_d), 0);
    chk("midrst_nibbles", longint'(q.size()), 0);
    q.delete();
    tick();
    rst = 1'b0;
    ref_t = longint'($time);
    push_init();
    wait_ready("reinit", cyc);
    chk("reinit_done", longint'(init_done), 1);
    chk("reinit_nibbles", longint'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
